// File: rtl/spinn_aer_dump_pkg.sv
// Shared encodings and defaults for the multi-channel AER dump mux.
// PKT_BITS normally arrives from the SpiNNaker link header as `PKT_BITS.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

package spinn_aer_dump_pkg;
  localparam int PKT_BITS_DFLT  = `PKT_BITS;
  localparam int CNT_BITS_DFLT  = 16;
  localparam int STAT_BITS_DFLT = 16;
  localparam int STATE_BITS     = 1;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE_ST = 1'b0,
    DUMP_ST = 1'b1
  } state_t;
endpackage

// File: rtl/spinn_aer_dump_ch.sv
// One dump channel: output register slice, busy-streak counter, dump FSM and
// optional drop counter (built only when SPINN_AER_DUMP_STATS_EN is defined).
module spinn_aer_dump_ch
  import spinn_aer_dump_pkg::*;
#(
  parameter int PKT_BITS  = PKT_BITS_DFLT,
  parameter int CNT_BITS  = CNT_BITS_DFLT,
  parameter int STAT_BITS = STAT_BITS_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [CNT_BITS-1:0]  dump_thresh,
  input  logic                 stats_clr,
  input  logic [PKT_BITS-1:0]  mpkt_data,
  input  logic                 mpkt_vld,
  output logic                 mpkt_rdy,
  output logic [PKT_BITS-1:0]  ipkt_data,
  output logic                 ipkt_vld,
  input  logic                 ipkt_rdy,
  output logic                 dump_mode,
  output logic [STAT_BITS-1:0] drop_cnt
);
  state_t              state;
  logic [CNT_BITS-1:0] ctr;
  logic [CNT_BITS:0]   ctr_inc;
  logic                busy, accept, load, thresh_hit;

  assign busy       = ipkt_vld && !ipkt_rdy;
  assign dump_mode  = (state == DUMP_ST);
  assign mpkt_rdy   = !go || dump_mode || !ipkt_vld || ipkt_rdy;
  assign accept     = mpkt_vld && mpkt_rdy;
  assign load       = accept && go && !dump_mode;
  // Extra bit so a saturated ctr still compares correctly against the threshold.
  assign ctr_inc    = {1'b0, ctr} + 1'b1;
  assign thresh_hit = (dump_thresh != '0) && (ctr_inc >= {1'b0, dump_thresh});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE_ST;
      ctr       <= '0;
      ipkt_vld  <= 1'b0;
      ipkt_data <= '0;
    end else begin
      if (!busy)          ctr <= '0;
      else if (ctr != '1) ctr <= ctr + 1'b1;

      case (state)
        IDLE_ST: if (busy && thresh_hit) state <= DUMP_ST;
        DUMP_ST: if (!busy)              state <= IDLE_ST;
        default:                         state <= IDLE_ST;
      endcase

      // Load takes priority over consume so back-to-back traffic has no bubble.
      if (load) begin
        ipkt_vld  <= 1'b1;
        ipkt_data <= mpkt_data;
      end else if (ipkt_vld && ipkt_rdy) begin
        ipkt_vld  <= 1'b0;
      end
    end
  end

`ifdef SPINN_AER_DUMP_STATS_EN
  logic drop;
  assign drop = accept && !load;

  always_ff @(posedge clk) begin
    if (rst || stats_clr)            drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign drop_cnt         = '0;
`endif
endmodule

// File: rtl/spinn_aer_dump_mux.sv
// NUM_CH independent AER-to-SpiNNaker dump channels; packs/unpacks the vectors.
// Optional drop statistics via SPINN_AER_DUMP_STATS_EN.
module spinn_aer_dump_mux
  import spinn_aer_dump_pkg::*;
#(
  parameter int PKT_BITS  = PKT_BITS_DFLT,
  parameter int NUM_CH    = 4,
  parameter int CNT_BITS  = CNT_BITS_DFLT,
  parameter int STAT_BITS = STAT_BITS_DFLT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  input  logic [CNT_BITS-1:0]           dump_thresh,
  output logic [NUM_CH-1:0]             dump_mode,
  input  logic [NUM_CH*PKT_BITS-1:0]    mpkt_data,
  input  logic [NUM_CH-1:0]             mpkt_vld,
  output logic [NUM_CH-1:0]             mpkt_rdy,
  output logic [NUM_CH*PKT_BITS-1:0]    ipkt_data,
  output logic [NUM_CH-1:0]             ipkt_vld,
  input  logic [NUM_CH-1:0]             ipkt_rdy,
  input  logic                          stats_clr,
  output logic [NUM_CH*STAT_BITS-1:0]   drop_cnt
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spinn_aer_dump_ch #(
      .PKT_BITS (PKT_BITS),
      .CNT_BITS (CNT_BITS),
      .STAT_BITS(STAT_BITS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .go         (go),
      .dump_thresh(dump_thresh),
      .stats_clr  (stats_clr),
      .mpkt_data  (mpkt_data[i*PKT_BITS +: PKT_BITS]),
      .mpkt_vld   (mpkt_vld[i]),
      .mpkt_rdy   (mpkt_rdy[i]),
      .ipkt_data  (ipkt_data[i*PKT_BITS +: PKT_BITS]),
      .ipkt_vld   (ipkt_vld[i]),
      .ipkt_rdy   (ipkt_rdy[i]),
      .dump_mode  (dump_mode[i]),
      .drop_cnt   (drop_cnt[i*STAT_BITS +: STAT_BITS])
    );
  end
endmodule

// File: tb/tb_spinn_aer_dump_mux.sv
// Directed bench for spinn_aer_dump_mux: streaming, dump entry/exit, threshold
// handling, go gating and (when built with the macro) drop statistics.
module tb_spinn_aer_dump_mux;
  import spinn_aer_dump_pkg::*;
  localparam int PB = PKT_BITS_DFLT;
  localparam int NC = 4;
  localparam int CB = 16;
  localparam int SB = 4;

  logic             clk = 0;
  logic             rst, go, stats_clr;
  logic [CB-1:0]    dump_thresh;
  logic [NC-1:0]    dump_mode, mpkt_vld, mpkt_rdy, ipkt_vld, ipkt_rdy;
  logic [NC*PB-1:0] mpkt_data, ipkt_data;
  logic [NC*SB-1:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  spinn_aer_dump_mux #(.PKT_BITS(PB), .NUM_CH(NC), .CNT_BITS(CB), .STAT_BITS(SB)) dut (
    .clk(clk), .rst(rst), .go(go), .dump_thresh(dump_thresh), .dump_mode(dump_mode),
    .mpkt_data(mpkt_data), .mpkt_vld(mpkt_vld), .mpkt_rdy(mpkt_rdy),
    .ipkt_data(ipkt_data), .ipkt_vld(ipkt_vld), .ipkt_rdy(ipkt_rdy),
    .stats_clr(stats_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [PB-1:0] pk(input int ch, input int k);
    logic [PB-1:0] r;
    r = '0;
    r[23:16] = ch[7:0];
    r[15:0]  = k[15:0];
    return r;
  endfunction

  function automatic int exp_drop(input int n);
`ifdef SPINN_AER_DUMP_STATS_EN
    return (n > 15) ? 15 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; go = 1; stats_clr = 0; dump_thresh = 16'd8;
    mpkt_vld = '0; mpkt_data = '0; ipkt_rdy = '1;
    tick(); tick();
    rst = 0;
    #1;
    tests++;
    if (ipkt_vld !== '0 || ipkt_data !== '0) begin
      fails++; $display("FAIL reset_out vld=%h data_nonzero=%0d req vld=0 data=0", ipkt_vld, ipkt_data != '0);
    end
    tests++;
    if (dump_mode !== '0 || drop_cnt !== '0) begin
      fails++; $display("FAIL reset_state dump=%b drop=%h req 0/0", dump_mode, drop_cnt);
    end
    tests++;
    if (mpkt_rdy !== 4'hF) begin
      fails++; $display("FAIL reset_rdy got=%b req=1111", mpkt_rdy);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    go = 1; dump_thresh = 16'd8; ipkt_rdy = '1;
    for (int k = 0; k < 100; k++) begin
      mpkt_vld = '1;
      for (int c = 0; c < NC; c++) mpkt_data[c*PB +: PB] = pk(c, k);
      tick();
      if (ipkt_vld !== 4'hF || dump_mode !== 4'h0) bad++;
      for (int c = 0; c < NC; c++)
        if (ipkt_data[c*PB +: PB] !== pk(c, k)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL stream_order errors=%0d req=0", bad);
    end
    mpkt_vld = '0;
    tick();
    tests++;
    if (ipkt_vld !== 4'h0) begin
      fails++; $display("FAIL stream_drain vld=%b req=0000", ipkt_vld);
    end
  endtask

  task automatic test_dump();
    int bad = 0;
    int k = 200;
    go = 1; dump_thresh = 16'd8; ipkt_rdy = 4'b1011;
    mpkt_vld = '1;
    for (int c = 0; c < NC; c++) mpkt_data[c*PB +: PB] = pk(c, k);
    tick();
    // ch2 now holds pk(2,200) and is busy; keep offering new packets
    for (int b = 0; b < 8; b++) begin
      k++;
      for (int c = 0; c < NC; c++) mpkt_data[c*PB +: PB] = pk(c, k);
      #1;
      if (dump_mode[2] !== 1'b0 || mpkt_rdy[2] !== 1'b0) bad++;
      if (mpkt_rdy[0] !== 1'b1 || mpkt_rdy[1] !== 1'b1 || mpkt_rdy[3] !== 1'b1) bad++;
      tick();
      if (ipkt_data[0*PB +: PB] !== pk(0, k) || ipkt_data[3*PB +: PB] !== pk(3, k)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL dump_pre errors=%0d req=0", bad);
    end
    tests++;
    if (dump_mode !== 4'b0100 || mpkt_rdy[2] !== 1'b1) begin
      fails++; $display("FAIL dump_enter dump=%b rdy2=%b req 0100/1", dump_mode, mpkt_rdy[2]);
    end
    bad = 0;
    for (int d = 0; d < 3; d++) begin
      k++;
      for (int c = 0; c < NC; c++) mpkt_data[c*PB +: PB] = pk(c, k);
      tick();
      if (ipkt_vld[2] !== 1'b1 || ipkt_data[2*PB +: PB] !== pk(2, 200)) bad++;
      if (dump_mode !== 4'b0100 || ipkt_data[1*PB +: PB] !== pk(1, k)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL dump_hold errors=%0d req=0", bad);
    end
    tests++;
    if (drop_cnt[2*SB +: SB] !== SB'(exp_drop(3)) || drop_cnt[0 +: SB] !== '0) begin
      fails++; $display("FAIL dump_dropcnt got=%h req ch2=%0d", drop_cnt, exp_drop(3));
    end
    // Release: held packet consumed, dump exits on this edge
    ipkt_rdy = '1; mpkt_vld = 4'b0000;
    tick();
    tests++;
    if (dump_mode !== 4'b0000 || ipkt_vld[2] !== 1'b0) begin
      fails++; $display("FAIL dump_exit dump=%b vld2=%b req 0000/0", dump_mode, ipkt_vld[2]);
    end
    mpkt_vld = 4'b0100; mpkt_data[2*PB +: PB] = pk(2, 300);
    tick();
    tests++;
    if (ipkt_vld[2] !== 1'b1 || ipkt_data[2*PB +: PB] !== pk(2, 300)) begin
      fails++; $display("FAIL dump_resume vld2=%b data=%h req 1/%h", ipkt_vld[2], ipkt_data[2*PB +: PB], pk(2, 300));
    end
    mpkt_vld = '0;
    stats_clr = 1;
    tick();
    stats_clr = 0;
  endtask

  task automatic test_thresh_zero();
    int bad = 0;
    dump_thresh = '0; ipkt_rdy = 4'b1101;
    mpkt_vld = 4'b0010; mpkt_data[1*PB +: PB] = pk(1, 400);
    tick();
    for (int n = 0; n < 1000; n++) begin
      mpkt_data[1*PB +: PB] = pk(1, 401 + n);
      #1;
      if (dump_mode[1] !== 1'b0 || mpkt_rdy[1] !== 1'b0) bad++;
      tick();
    end
    tests++;
    if (bad != 0 || ipkt_data[1*PB +: PB] !== pk(1, 400)) begin
      fails++; $display("FAIL thresh_zero errors=%0d data=%h req 0/%h", bad, ipkt_data[1*PB +: PB], pk(1, 400));
    end
    ipkt_rdy = '1; mpkt_vld = '0;
    tick();
  endtask

  task automatic test_thresh_lower();
    dump_thresh = 16'd100; ipkt_rdy = 4'b1110;
    mpkt_vld = 4'b0001; mpkt_data[0 +: PB] = pk(0, 500);
    tick();
    mpkt_vld = '0;
    for (int n = 0; n < 20; n++) tick();
    tests++;
    if (dump_mode[0] !== 1'b0) begin
      fails++; $display("FAIL thresh_hi dump0=%b req=0", dump_mode[0]);
    end
    dump_thresh = 16'd5;
    tick();
    tests++;
    if (dump_mode[0] !== 1'b1) begin
      fails++; $display("FAIL thresh_lower dump0=%b req=1", dump_mode[0]);
    end
    ipkt_rdy = '1;
    tick();
  endtask

  task automatic test_go_off();
    int bad = 0;
    dump_thresh = 16'd8;
    // Stalled packet on ch3 must survive go dropping
    ipkt_rdy = 4'b0111; go = 1;
    mpkt_vld = 4'b1000; mpkt_data[3*PB +: PB] = pk(3, 600);
    tick();
    go = 0;
    mpkt_vld = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      mpkt_data[0 +: PB] = pk(0, 700 + n);
      #1;
      if (mpkt_rdy[0] !== 1'b1) bad++;
      tick();
      if (ipkt_vld[0] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL go_off errors=%0d req=0", bad);
    end
    tests++;
    if (ipkt_vld[3] !== 1'b1 || ipkt_data[3*PB +: PB] !== pk(3, 600)) begin
      fails++; $display("FAIL go_noflush vld3=%b data=%h req 1/%h", ipkt_vld[3], ipkt_data[3*PB +: PB], pk(3, 600));
    end
    tests++;
    if (drop_cnt[0 +: SB] !== SB'(exp_drop(10))) begin
      fails++; $display("FAIL drop10 got=%0d req=%0d", drop_cnt[0 +: SB], exp_drop(10));
    end
    ipkt_rdy = '1;
    for (int n = 0; n < 10; n++) tick();
    tests++;
    if (drop_cnt[0 +: SB] !== SB'(exp_drop(20))) begin
      fails++; $display("FAIL drop_sat got=%0d req=%0d", drop_cnt[0 +: SB], exp_drop(20));
    end
    stats_clr = 1;
    tick();
    stats_clr = 0;
    tests++;
    if (drop_cnt !== '0) begin
      fails++; $display("FAIL drop_clr got=%h req=0", drop_cnt);
    end
    mpkt_vld = '0; go = 1;
    tick();
  endtask

  task automatic test_mid_reset();
    ipkt_rdy = 4'b0000; dump_thresh = 16'd2;
    mpkt_vld = '1;
    for (int c = 0; c < NC; c++) mpkt_data[c*PB +: PB] = pk(c, 800);
    for (int n = 0; n < 4; n++) tick();
    tests++;
    if (dump_mode !== 4'hF) begin
      fails++; $display("FAIL pre_reset dump=%b req=1111", dump_mode);
    end
    rst = 1; mpkt_vld = '0;
    tick();
    rst = 0;
    #1;
    tests++;
    if (dump_mode !== '0 || ipkt_vld !== '0 || mpkt_rdy !== 4'hF) begin
      fails++; $display("FAIL mid_reset dump=%b vld=%b rdy=%b req 0000/0000/1111", dump_mode, ipkt_vld, mpkt_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_dump();
    test_thresh_zero();
    test_thresh_lower();
    test_go_off();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
